// File: rtl/wid_pack_pkg.sv
// Shared types and helpers for the mixed-width byte packer.
// Beat size encoding, FSM states, buffer geometry, lane helpers.
package wid_pack_pkg;

   localparam int BUF_BYTES = 8;
   localparam int OUT_BYTES = 4;

   typedef enum logic [1:0] {
      SZ_1B  = 2'd0,
      SZ_2B  = 2'd1,
      SZ_4B  = 2'd2,
      SZ_BAD = 2'd3
   } size_e;

   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // Bytes contributed by one beat; an illegal size adds nothing.
   function automatic logic [2:0] size_to_bytes(size_e sz);
      logic [2:0] n;
      case (sz)
         SZ_1B:   n = 3'd1;
         SZ_2B:   n = 3'd2;
         SZ_4B:   n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   // Lane mask for the oldest min(cnt,4) bytes.
   function automatic logic [3:0] strb_for_count(logic [3:0] cnt);
      logic [3:0] s;
      case (cnt)
         4'd0:    s = 4'b0000;
         4'd1:    s = 4'b0001;
         4'd2:    s = 4'b0011;
         4'd3:    s = 4'b0111;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/wid_mixed_width_packer.sv
// Packs 1/2/4-byte beats little-endian into a dense 32-bit stream.
// Ports: clk, rst (async high); in_valid/in_ready/in_data/in_size
// upstream beats; flush requests emission of the residual partial
// word; out_valid/out_ready/out_data/out_strb/out_last downstream;
// flush_done pulse, sticky err_size, byte_count occupancy (0..8).
module wid_mixed_width_packer
   import wid_pack_pkg::*;
#(
   parameter logic [7:0] PAD_BYTE    = 8'h00,
   parameter bit         STRICT_SIZE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_size,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_strb,
   output logic        out_last,
   output logic        flush_done,
   output logic        err_size,
   output logic [3:0]  byte_count
);

   state_e                      state_q;
   state_e                      state_d;
   logic [BUF_BYTES-1:0][7:0]   data_q;
   logic [BUF_BYTES-1:0][7:0]   data_d;
   logic [3:0]                  count_q;
   logic [3:0]                  count_d;
   logic                        err_q;
   logic                        done_q;
   logic                        done_d;

   logic                        push;
   logic                        pop;
   logic [2:0]                  push_n;
   logic [3:0]                  pop_n;
   logic [3:0]                  base;
   logic [3:0]                  pos;

   // Handshakes and occupancy update.
   always_comb begin
      push    = in_valid & in_ready;
      push_n  = push ? size_to_bytes(size_e'(in_size)) : 3'd0;
      pop     = out_valid & out_ready;
      pop_n   = 4'd0;
      if (pop) begin
         pop_n = (count_q >= 4'd4) ? 4'd4 : count_q;
      end
      count_d = count_q - pop_n + {1'b0, push_n};
   end

   // Buffer shift-down on pop, then append new bytes after the
   // survivors. Push only happens with count<=4, so base+j <= 7.
   always_comb begin
      data_d = data_q;
      base   = count_q - pop_n;
      pos    = 4'd0;
      if (pop) begin
         data_d = data_q >> 32;
      end
      for (int j = 0; j < OUT_BYTES; j++) begin
         if (3'(j) < push_n) begin
            pos = base + 4'(j);
            data_d[pos[2:0]] = in_data[8*j +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         count_q <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         count_q <= count_d;
         if (STRICT_SIZE && push && (in_size == 2'd3)) begin
            err_q <= 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCUM;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // FSM next state. A flush that leaves nothing buffered (beat of
   // this cycle included) completes at once without a word.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         ACCUM: begin
            if (flush) begin
               if (count_d == 4'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && out_last) begin
               state_d = ACCUM;
               done_d  = 1'b1;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // FSM outputs, from registered state only.
   always_comb begin
      in_ready  = (state_q == ACCUM) && (count_q <= 4'd4);
      if (state_q == ACCUM) begin
         out_valid = (count_q >= 4'd4);
      end else begin
         out_valid = (count_q != 4'd0);
      end
      out_strb  = out_valid ? strb_for_count(count_q) : 4'h0;
      out_last  = (state_q == DRAIN) && out_valid &&
                  (count_q <= 4'd4);
      out_data  = 32'h0;
      for (int i = 0; i < OUT_BYTES; i++) begin
         if (out_valid) begin
            out_data[8*i +: 8] = out_strb[i] ? data_q[i] : PAD_BYTE;
         end
      end
      flush_done = done_q;
      err_size   = err_q;
      byte_count = count_q;
   end

endmodule

// File: doc/wid_mixed_width_packer.md
Name: wid_mixed_width_packer

Overview:
- Consumes a stream of mixed-size constants and data words (1, 2 or 4 bytes per beat) from upstream register stages. Examples of such stages are 8-bit, 16-bit and 32-bit registered outputs.
- Packs the bytes little-endian into a dense 32-bit output stream with byte strobes.
- Supports explicit flush of a partial word, marked with out_last.
- Sits directly downstream of the width-typed register stages. Feeds the 32-bit bus interface.

Parameters:
- PAD_BYTE, 8'h00, value driven on unused byte lanes of a partial (flushed) word.
- STRICT_SIZE, 1, 1: illegal in_size sets err_size; 0: illegal size silently dropped.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  packer can accept a beat.
- in_data  input  32  payload, byte 0 = in_data[7:0].
- in_size  input  2  0=1 byte, 1=2 bytes, 2=4 bytes, 3=illegal.
- flush  input  1  single-cycle request to emit the residual partial word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts word.
- out_data  output  32  packed word, oldest byte in [7:0].
- out_strb  output  4  byte-lane valid mask.
- out_last  output  1  final word of a flush.
- flush_done  output  1  one-cycle pulse when flush completes.
- err_size  output  1  sticky illegal-size flag.
- byte_count  output  4  current buffer occupancy, 0..8.

Behaviour:
- Reset (async, rst=1): buffer bytes 0, count 0, state ACCUM. Outputs: out_valid 0, out_strb 0, out_data 0, out_last 0, flush_done 0, err_size 0, in_ready 1 after release.
- Buffer: 8 bytes. count is 4 bits, 0..8. Push appends n bytes at position count. Pop removes bytes [3:0] and shifts down by 4. Push and pop may occur in the same cycle.
- Push: in_valid & in_ready. n = 1/2/4 per in_size. Size 3 adds 0 bytes and sets err_size if STRICT_SIZE.
- in_ready = (state==ACCUM) & (count<=4). It depends on registered state only, with no comb path from out_ready.
- out_valid, ACCUM state: count>=4. Then out_strb=4'hF, out_last=0.
- out_valid, DRAIN state: count>0.
  - If count>=4: full word. out_last=1 only if count==4.
  - If count<4: out_strb=(1<<count)-1, unused lanes = PAD_BYTE, out_last=1.
- out_data and out_strb are driven from registered buffer and count only; they are stable while out_valid & !out_ready.
- Pop: out_valid & out_ready. count_next = count - min(count,4) + n.
- Latency: a beat completing 4 bytes, accepted at edge N, presents out_valid after edge N. Steady 4-byte traffic with out_ready=1 sustains one word per cycle.
- FSM:
  - ACCUM -> DRAIN on flush. A beat accepted in the same cycle is included in the flush.
  - DRAIN -> ACCUM on the pop with out_last=1, or immediately if count==0 at flush (emits no word).
  - flush_done pulses 1 cycle on the DRAIN->ACCUM transition.
  - Flush asserted while in DRAIN is ignored.
- Backpressure: with out_ready=0 and count>4, in_ready=0; no data loss.
- Reset mid-operation: buffer contents are discarded, the FSM returns to ACCUM, and no word is emitted.

Decomposition:
- Shared package wid_pack_pkg:
  - size_e enum: SZ_1B, SZ_2B, SZ_4B, SZ_BAD.
  - state_e: ACCUM, DRAIN.
  - BUF_BYTES=8, OUT_BYTES=4.
  - function size_to_bytes(size_e) returning 3 bits.
  - function strb_for_count(count) returning 4 bits.
- No sub-module required. Buffer shift/insert logic stays in one always_ff plus one always_comb.

Test Plan:
- Push 8'hAB (sz0), 16'hCDEF (sz1), 8'h12 (sz0) -> one word out_data=32'h12CDEFAB, out_strb=4'hF, out_last=0.
- Back-to-back 32'h11223344, 32'h55667788 with out_ready=1 -> words on consecutive cycles, in_ready held 1, byte_count stays 4.
- Push 16'hABCD then flush -> out_data=32'h0000ABCD, out_strb=4'b0011, out_last=1, then flush_done pulse, byte_count=0.
- out_ready=0, push three 4-byte beats -> third beat stalls (in_ready=0 at count=8). Release out_ready -> words 1..2 are emitted intact, then word 3 is accepted.
- in_size=3 with data 32'hDEADBEEF -> beat consumed, byte_count unchanged, err_size=1 until rst; with STRICT_SIZE=0, err_size stays 0.
- Assert rst mid-accumulation at count=3 -> out_valid=0 and byte_count=0 immediately. The next 4-byte beat emits cleanly.
